// File: rtl/bg_pkg.sv
// Shared encodings for the frame-synchronous background selector:
// mode values and the flash burst state machine.
package bg_pkg;

   localparam logic [1:0] MODE_MANUAL = 2'd0;
   localparam logic [1:0] MODE_AUTO   = 2'd1;

   typedef enum logic {
      FL_NORMAL = 1'b0,
      FL_FLASH  = 1'b1
   } fl_state_e;

endpackage : bg_pkg

// File: rtl/bg_mux_n.sv
// Combinational selector over a packed bus of NUM_BG colours,
// each COLOR_W bits wide; out-of-range selects yield zero.
module bg_mux_n #(
   parameter int NUM_BG  = 8,
   parameter int COLOR_W = 3,
   parameter int SEL_W   = $clog2(NUM_BG)
) (
   input  logic [NUM_BG*COLOR_W-1:0] data_in,
   input  logic [SEL_W-1:0]          sel,
   output logic [COLOR_W-1:0]        data_out
);

   // pick the colour slot addressed by sel
   always_comb begin
      data_out = '0;
      for (int i = 0; i < NUM_BG; i++) begin
         if (sel == SEL_W'(i)) begin
            data_out = data_in[i*COLOR_W +: COLOR_W];
         end else begin
            data_out = data_out;
         end
      end
   end

endmodule : bg_mux_n

// File: rtl/bg_frame_switch.sv
// Background selector that only switches on frame boundaries, with an
// auto-cycle mode and a timed flash overlay; the colour output is registered.
module bg_frame_switch
   import bg_pkg::*;
#(
   parameter int NUM_BG       = 8,
   parameter int COLOR_W      = 3,
   parameter int SEL_W        = $clog2(NUM_BG),
   parameter int CYCLE_FRAMES = 60,
   parameter int FLASH_FRAMES = 8,
   parameter int FLASH_BG     = NUM_BG - 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_BG*COLOR_W-1:0] bg_colors,
   input  logic                      frame_start,
   input  logic [1:0]                mode,
   input  logic [SEL_W-1:0]          sel_req,
   input  logic                      sel_valid,
   output logic                      sel_ready,
   input  logic                      flash_trig,
   output logic [COLOR_W-1:0]        color,
   output logic [SEL_W-1:0]          active_bg,
   output logic                      switched,
   output logic                      flashing,
   output logic                      sel_err
);

   localparam int CNT_W = $clog2(CYCLE_FRAMES + 1);
   localparam int FL_W  = $clog2(FLASH_FRAMES + 1);
   localparam logic [SEL_W:0]   NUM_BG_EXT = (SEL_W + 1)'(NUM_BG);
   localparam logic [SEL_W-1:0] LAST_IDX   = SEL_W'(NUM_BG - 1);
   localparam logic [SEL_W-1:0] FLASH_IDX  = SEL_W'(FLASH_BG);
   localparam logic [CNT_W-1:0] CYC_LAST   = CNT_W'(CYCLE_FRAMES - 1);
   localparam logic [FL_W-1:0]  FL_LAST    = FL_W'(FLASH_FRAMES - 1);

   logic              pend_valid_q, pend_valid_d;
   logic [SEL_W-1:0]  pend_idx_q, pend_idx_d;
   logic [SEL_W-1:0]  active_bg_q, active_bg_d;
   logic [CNT_W-1:0]  fcnt_q, fcnt_d;
   logic              switched_q, switched_d;
   logic              sel_err_q, sel_err_d;
   logic [COLOR_W-1:0] color_q, color_d;
   fl_state_e         fl_state_q;
   logic [FL_W-1:0]   fl_cnt_q;
   logic              fl_phase_q;
   logic [SEL_W-1:0]  sel_idx;
   logic              flashing_s;
   logic              auto_s;

   assign flashing_s = (fl_state_q == FL_FLASH);
   assign auto_s     = (mode == MODE_AUTO);

   // request slot, frame counter and background switching
   always_comb begin
      pend_valid_d = pend_valid_q;
      pend_idx_d   = pend_idx_q;
      active_bg_d  = active_bg_q;
      fcnt_d       = fcnt_q;
      switched_d   = 1'b0;
      sel_err_d    = 1'b0;

      if (!auto_s) begin
         fcnt_d = '0;
      end else begin
         fcnt_d = fcnt_q;
      end

      // pending request is sampled from the register, so one accepted
      // alongside frame_start waits for the next boundary
      if (frame_start) begin
         if (pend_valid_q) begin
            active_bg_d  = pend_idx_q;
            pend_valid_d = 1'b0;
            fcnt_d       = '0;
            switched_d   = 1'b1;
         end else if (auto_s && !flashing_s) begin
            if (fcnt_q == CYC_LAST) begin
               active_bg_d = (active_bg_q == LAST_IDX) ? '0 : active_bg_q + SEL_W'(1);
               fcnt_d      = '0;
               switched_d  = 1'b1;
            end else begin
               fcnt_d = fcnt_q + CNT_W'(1);
            end
         end else begin
            active_bg_d = active_bg_q;
         end
      end else begin
         active_bg_d = active_bg_q;
      end

      if (sel_valid && !pend_valid_q) begin
         if ({1'b0, sel_req} < NUM_BG_EXT) begin
            pend_valid_d = 1'b1;
            pend_idx_d   = sel_req;
         end else begin
            sel_err_d = 1'b1;
         end
      end else begin
         sel_err_d = 1'b0;
      end
   end

   // colour source: flash background during "on" phases, else active
   always_comb begin
      if (flashing_s && fl_phase_q) begin
         sel_idx = FLASH_IDX;
      end else begin
         sel_idx = active_bg_q;
      end
   end

   bg_mux_n #(
      .NUM_BG  (NUM_BG),
      .COLOR_W (COLOR_W),
      .SEL_W   (SEL_W)
   ) u_mux (
      .data_in  (bg_colors),
      .sel      (sel_idx),
      .data_out (color_d)
   );

   // state registers for the switching datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_valid_q <= 1'b0;
         pend_idx_q   <= '0;
         active_bg_q  <= '0;
         fcnt_q       <= '0;
         switched_q   <= 1'b0;
         sel_err_q    <= 1'b0;
         color_q      <= '0;
      end else begin
         pend_valid_q <= pend_valid_d;
         pend_idx_q   <= pend_idx_d;
         active_bg_q  <= active_bg_d;
         fcnt_q       <= fcnt_d;
         switched_q   <= switched_d;
         sel_err_q    <= sel_err_d;
         color_q      <= color_d;
      end
   end

   // flash burst FSM; a trigger restarts the burst and beats frame_start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fl_state_q <= FL_NORMAL;
         fl_cnt_q   <= '0;
         fl_phase_q <= 1'b0;
      end else begin
         case (fl_state_q)
            FL_NORMAL: begin
               if (flash_trig) begin
                  fl_state_q <= FL_FLASH;
                  fl_cnt_q   <= '0;
                  fl_phase_q <= 1'b1;
               end
            end
            FL_FLASH: begin
               if (flash_trig) begin
                  fl_cnt_q   <= '0;
                  fl_phase_q <= 1'b1;
               end else if (frame_start) begin
                  if (fl_cnt_q == FL_LAST) begin
                     fl_state_q <= FL_NORMAL;
                     fl_cnt_q   <= '0;
                     fl_phase_q <= 1'b0;
                  end else begin
                     fl_cnt_q   <= fl_cnt_q + FL_W'(1);
                     fl_phase_q <= ~fl_phase_q;
                  end
               end
            end
            default: begin
               fl_state_q <= FL_NORMAL;
               fl_cnt_q   <= '0;
               fl_phase_q <= 1'b0;
            end
         endcase
      end
   end

   assign sel_ready = ~pend_valid_q;
   assign color     = color_q;
   assign active_bg = active_bg_q;
   assign switched  = switched_q;
   assign flashing  = flashing_s;
   assign sel_err   = sel_err_q;

endmodule : bg_frame_switch

// File: tb/tb_bg_frame_switch.sv
// Directed bench for bg_frame_switch: six backgrounds (colour i = i, flash
// index 5) so out-of-range requests are representable in the select width.
module tb_bg_frame_switch;

   localparam int NUM_BG  = 6;
   localparam int COLOR_W = 3;
   localparam int SEL_W   = 3;

   logic                      clk;
   logic                      rst_n;
   logic [NUM_BG*COLOR_W-1:0] bg_colors;
   logic                      frame_start;
   logic [1:0]                mode;
   logic [SEL_W-1:0]          sel_req;
   logic                      sel_valid;
   logic                      sel_ready;
   logic                      flash_trig;
   logic [COLOR_W-1:0]        color;
   logic [SEL_W-1:0]          active_bg;
   logic                      switched;
   logic                      flashing;
   logic                      sel_err;

   int n_checks;
   int n_fail;

   bg_frame_switch #(
      .NUM_BG       (NUM_BG),
      .COLOR_W      (COLOR_W),
      .SEL_W        (SEL_W),
      .CYCLE_FRAMES (2),
      .FLASH_FRAMES (4),
      .FLASH_BG     (5)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bg_colors   (bg_colors),
      .frame_start (frame_start),
      .mode        (mode),
      .sel_req     (sel_req),
      .sel_valid   (sel_valid),
      .sel_ready   (sel_ready),
      .flash_trig  (flash_trig),
      .color       (color),
      .active_bg   (active_bg),
      .switched    (switched),
      .flashing    (flashing),
      .sel_err     (sel_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic frame();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
   endtask

   task automatic request(input int idx);
      sel_req   = SEL_W'(idx);
      sel_valid = 1'b1;
      step();
      sel_valid = 1'b0;
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      rst_n       = 1'b0;
      frame_start = 1'b0;
      mode        = 2'd0;
      sel_req     = '0;
      sel_valid   = 1'b0;
      flash_trig  = 1'b0;
      for (int i = 0; i < NUM_BG; i++) bg_colors[i*COLOR_W +: COLOR_W] = COLOR_W'(i);
      step();
      step();
      check_eq("rst_color", int'(color), 0);
      check_eq("rst_active", int'(active_bg), 0);
      check_eq("rst_switched", int'(switched), 0);
      check_eq("rst_flashing", int'(flashing), 0);
      check_eq("rst_sel_err", int'(sel_err), 0);
      check_eq("rst_ready", int'(sel_ready), 1);
      rst_n = 1'b1;
      step();

      // manual request waits for a frame boundary
      request(5);
      check_eq("req5_ready_low", int'(sel_ready), 0);
      step(); step(); step();
      check_eq("req5_no_early", int'(active_bg), 0);
      check_eq("req5_no_early_sw", int'(switched), 0);
      frame();
      check_eq("req5_active", int'(active_bg), 5);
      check_eq("req5_switched", int'(switched), 1);
      check_eq("req5_ready_back", int'(sel_ready), 1);
      check_eq("req5_color_lag", int'(color), 0);
      step();
      check_eq("req5_color", int'(color), 5);
      check_eq("req5_sw_pulse", int'(switched), 0);

      // request coinciding with frame_start waits one more frame
      sel_req = 3'd3; sel_valid = 1'b1; frame_start = 1'b1;
      step();
      sel_valid = 1'b0; frame_start = 1'b0;
      check_eq("coin_active", int'(active_bg), 5);
      check_eq("coin_switched", int'(switched), 0);
      check_eq("coin_ready", int'(sel_ready), 0);
      request(1);
      check_eq("held_ready", int'(sel_ready), 0);
      frame();
      check_eq("coin_applied", int'(active_bg), 3);
      check_eq("coin_applied_sw", int'(switched), 1);
      step();
      check_eq("coin_color", int'(color), 3);
      frame();
      check_eq("held_dropped", int'(active_bg), 3);
      check_eq("held_dropped_sw", int'(switched), 0);

      // out-of-range request
      request(7);
      check_eq("oor_err", int'(sel_err), 1);
      check_eq("oor_ready", int'(sel_ready), 1);
      step();
      check_eq("oor_err_pulse", int'(sel_err), 0);
      frame();
      check_eq("oor_active", int'(active_bg), 3);
      check_eq("oor_no_sw", int'(switched), 0);

      // re-selecting the current background still pulses switched
      request(3);
      frame();
      check_eq("same_sw", int'(switched), 1);
      check_eq("same_active", int'(active_bg), 3);

      // combinational colour change shows one cycle later
      bg_colors[3*COLOR_W +: COLOR_W] = 3'd6;
      step();
      check_eq("bgchg_color", int'(color), 6);
      bg_colors[3*COLOR_W +: COLOR_W] = 3'd3;

      // AUTO wrap from the last index
      request(5);
      frame();
      mode = 2'd1;
      frame();
      check_eq("auto_hold", int'(active_bg), 5);
      check_eq("auto_hold_sw", int'(switched), 0);
      frame();
      check_eq("auto_wrap", int'(active_bg), 0);
      check_eq("auto_wrap_sw", int'(switched), 1);
      step();
      check_eq("auto_wrap_color", int'(color), 0);
      frame();
      request(4);
      frame();
      check_eq("auto_prio", int'(active_bg), 4);
      frame();
      check_eq("auto_restart", int'(active_bg), 4);
      frame();
      check_eq("auto_step", int'(active_bg), 5);

      // flash burst over background 2, AUTO frozen meanwhile
      mode = 2'd0;
      request(2);
      frame();
      mode = 2'd1;
      step();
      check_eq("pre_flash_color", int'(color), 2);
      flash_trig = 1'b1;
      step();
      flash_trig = 1'b0;
      check_eq("flash_on", int'(flashing), 1);
      step();
      check_eq("flash_c0", int'(color), 5);
      frame();
      step();
      check_eq("flash_c1", int'(color), 2);
      frame();
      check_eq("flash_auto_frozen", int'(active_bg), 2);
      step();
      check_eq("flash_c2", int'(color), 5);
      // retrigger coincident with frame_start: trigger must win
      flash_trig = 1'b1; frame_start = 1'b1;
      step();
      flash_trig = 1'b0; frame_start = 1'b0;
      step();
      check_eq("retrig_color", int'(color), 5);
      frame();
      frame();
      check_eq("retrig_extends", int'(flashing), 1);
      step();
      check_eq("retrig_c2", int'(color), 5);
      frame();
      check_eq("flash_still", int'(flashing), 1);
      frame();
      check_eq("flash_done", int'(flashing), 0);
      check_eq("flash_keep_active", int'(active_bg), 2);
      step();
      check_eq("flash_done_color", int'(color), 2);
      frame();
      check_eq("auto_resume_hold", int'(active_bg), 2);
      frame();
      check_eq("auto_resume", int'(active_bg), 3);

      // asynchronous reset mid-burst with a pending request
      mode = 2'd0;
      flash_trig = 1'b1;
      step();
      flash_trig = 1'b0;
      request(1);
      check_eq("pre_rst_flash", int'(flashing), 1);
      check_eq("pre_rst_ready", int'(sel_ready), 0);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_flashing", int'(flashing), 0);
      check_eq("arst_active", int'(active_bg), 0);
      check_eq("arst_color", int'(color), 0);
      check_eq("arst_ready", int'(sel_ready), 1);
      check_eq("arst_switched", int'(switched), 0);
      step();
      rst_n = 1'b1;
      step();
      frame();
      check_eq("post_rst_active", int'(active_bg), 0);
      check_eq("post_rst_no_sw", int'(switched), 0);
      step();
      check_eq("post_rst_color", int'(color), 0);
      check_eq("post_rst_flash", int'(flashing), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_bg_frame_switch
